// File: rtl/cnn_pkg.sv
// Shared defaults and state encoding for the CNN frame sequencer.
package cnn_pkg;

    localparam int DEF_IMG_DIM = 16;
    localparam int DEF_BEAT_W  = 16;
    localparam int DEF_BEATS   = DEF_IMG_DIM * DEF_IMG_DIM / DEF_BEAT_W;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESULT = 2'd2
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/cnn_frame_sequencer.sv
// Assembles a beat stream into the classifier image, waits for the combinational
// classifier to settle, then returns its verdict on a ready/valid port.
//
// state     | meaning
// ST_LOAD   | accepting image beats, img_bus partially updated
// ST_SETTLE | img_bus frozen, counting down before sampling cls_result
// ST_RESULT | verdict held on res_class until res_ready
module cnn_frame_sequencer
    import cnn_pkg::*;
#(
    parameter int IMG_DIM       = DEF_IMG_DIM,
    parameter int BEAT_W        = DEF_BEAT_W,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [BEAT_W-1:0]          in_data,
    input  logic                       in_last,
    output logic [IMG_DIM*IMG_DIM-1:0] img_bus,
    output logic                       img_stable,
    input  logic                       cls_result,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic                       res_class,
    output logic                       frame_err,
    output logic [CNT_W-1:0]           frame_cnt,
    output logic [CNT_W-1:0]           diseased_cnt
);

    localparam int IMG_W = IMG_DIM * IMG_DIM;
    localparam int BEATS = IMG_W / BEAT_W;
    localparam int BI_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SC_W  = $clog2(SETTLE_CYCLES + 1);

    state_e            state_q, state_d;
    logic [BI_W-1:0]   beat_idx_q, beat_idx_d;
    logic [SC_W-1:0]   settle_q, settle_d;
    logic [IMG_W-1:0]  img_q, img_d;
    logic              res_class_q, res_class_d;
    logic              frame_err_q, frame_err_d;
    logic              frame_inc, diseased_inc;
    logic              last_beat;

    assign last_beat = (beat_idx_q == BI_W'(BEATS - 1));

    always_comb begin
        state_d      = state_q;
        beat_idx_d   = beat_idx_q;
        settle_d     = settle_q;
        img_d        = img_q;
        res_class_d  = res_class_q;
        frame_err_d  = 1'b0;
        frame_inc    = 1'b0;
        diseased_inc = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    img_d[int'(beat_idx_q) * BEAT_W +: BEAT_W] = in_data;
                    if (in_last && last_beat) begin
                        state_d    = ST_SETTLE;
                        settle_d   = SC_W'(SETTLE_CYCLES - 1);
                        beat_idx_d = '0;
                    end else if (in_last || last_beat) begin
                        // Misframed: drop the partial frame and resync on the next beat.
                        frame_err_d = 1'b1;
                        beat_idx_d  = '0;
                    end else begin
                        beat_idx_d = beat_idx_q + 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                if (settle_q == '0) begin
                    res_class_d = cls_result;
                    state_d     = ST_RESULT;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            ST_RESULT: begin
                if (res_ready) begin
                    state_d      = ST_LOAD;
                    frame_inc    = 1'b1;
                    diseased_inc = res_class_q;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            beat_idx_q  <= '0;
            settle_q    <= '0;
            img_q       <= '0;
            res_class_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_idx_q  <= beat_idx_d;
            settle_q    <= settle_d;
            img_q       <= img_d;
            res_class_q <= res_class_d;
            frame_err_q <= frame_err_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_frame_cnt (
        .clk (clk),
        .rst (rst),
        .inc (frame_inc),
        .cnt (frame_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_diseased_cnt (
        .clk (clk),
        .rst (rst),
        .inc (diseased_inc),
        .cnt (diseased_cnt)
    );

    assign in_ready   = (state_q == ST_LOAD);
    assign img_stable = (state_q != ST_LOAD);
    assign res_valid  = (state_q == ST_RESULT);
    assign img_bus    = img_q;
    assign res_class  = res_class_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Directed bench for cnn_frame_sequencer; a second instance with 2-bit counters
// shares the stimulus to exercise counter saturation.
module tb_cnn_frame_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [15:0]  in_data;
    logic         in_last;
    logic [255:0] img_bus;
    logic         img_stable;
    logic         cls_result;
    logic         res_valid;
    logic         res_ready;
    logic         res_class;
    logic         frame_err;
    logic [15:0]  frame_cnt;
    logic [15:0]  diseased_cnt;

    logic         in_ready_s, img_stable_s, res_valid_s, res_class_s, frame_err_s;
    logic [255:0] img_bus_s;
    logic [1:0]   frame_cnt_s, diseased_cnt_s;

    int           n_checks = 0;
    int           n_err    = 0;
    logic [255:0] exp_img;

    always #5 clk = ~clk;

    cnn_frame_sequencer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .img_bus(img_bus),
        .img_stable(img_stable), .cls_result(cls_result), .res_valid(res_valid),
        .res_ready(res_ready), .res_class(res_class), .frame_err(frame_err),
        .frame_cnt(frame_cnt), .diseased_cnt(diseased_cnt)
    );

    cnn_frame_sequencer #(.CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .in_last(in_last), .img_bus(img_bus_s),
        .img_stable(img_stable_s), .cls_result(cls_result), .res_valid(res_valid_s),
        .res_ready(res_ready), .res_class(res_class_s), .frame_err(frame_err_s),
        .frame_cnt(frame_cnt_s), .diseased_cnt(diseased_cnt_s)
    );

    typedef struct {
        logic [15:0] base;
        logic [15:0] stride;
        logic        cls;
        logic        exp_class;
        logic [15:0] exp_fc;
        logic [15:0] exp_dc;
    } frame_vec_t;

    frame_vec_t vecs [4];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 40) begin
            step();
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
    endtask

    // Sends beats 0..nbeats-1 of base+stride*i; in_last on beat last_at.
    task automatic send_beats(input logic [15:0] base, input logic [15:0] stride,
                              input logic cls, input int nbeats, input int last_at);
        for (int i = 0; i < nbeats; i++) begin
            wait_ready();
            in_valid   = 1'b1;
            in_data    = base + stride * 16'(i);
            in_last    = (i == last_at);
            cls_result = cls;
            exp_img[i*16 +: 16] = in_data;
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_res();
        int n = 0;
        while (!res_valid && n < 40) begin
            step();
            n++;
        end
        chk("res_valid_timeout", res_valid, 1);
    endtask

    initial begin
        logic [15:0] fc0;
        rst = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        cls_result = 1'b0; res_ready = 1'b0; exp_img = '0;

        vecs[0] = '{16'hFFFF, 16'h0000, 1'b1, 1'b1, 16'd1, 16'd1};
        vecs[1] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'd2, 16'd1};
        vecs[2] = '{16'h0001, 16'h0101, 1'b1, 1'b1, 16'd3, 16'd2};
        vecs[3] = '{16'hA5A5, 16'h3C3C, 1'b0, 1'b0, 16'd4, 16'd2};

        do_reset();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_img_bus", img_bus, 0);
        chk("rst_img_stable", img_stable, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_class", res_class, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_diseased_cnt", diseased_cnt, 0);

        // Table-driven good frames: image assembly, latency, verdict, counters.
        for (int v = 0; v < 4; v++) begin
            send_beats(vecs[v].base, vecs[v].stride, vecs[v].cls, 16, 15);
            chk("settle_img_bus", img_bus, exp_img);
            chk("settle_img_stable", img_stable, 1);
            chk("settle_in_ready", in_ready, 0);
            step(); step(); step();
            chk("latency_early_res_valid", res_valid, 0);
            step();
            chk("latency_res_valid", res_valid, 1);
            chk("res_class", res_class, vecs[v].exp_class);
            chk("result_img_stable", img_stable, 1);
            res_ready = 1'b1;
            step();
            res_ready = 1'b0;
            chk("post_hs_res_valid", res_valid, 0);
            chk("post_hs_in_ready", in_ready, 1);
            chk("frame_cnt", frame_cnt, vecs[v].exp_fc);
            chk("diseased_cnt", diseased_cnt, vecs[v].exp_dc);
        end
        chk("img_all_ones", (vecs[0].base == 16'hFFFF) ? 256'd0 : 256'd1, 0);

        // Early in_last on beat 7, then late (missing) in_last on beat 15.
        do_reset();
        send_beats(16'h1111, 16'h0000, 1'b1, 8, 7);
        chk("early_last_frame_err", frame_err, 1);
        chk("early_last_in_ready", in_ready, 1);
        step();
        chk("frame_err_one_cycle", frame_err, 0);
        send_beats(16'h2222, 16'h0000, 1'b1, 16, 99);
        chk("late_last_frame_err", frame_err, 1);
        chk("late_last_img_stable", img_stable, 0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("err_no_res_valid", res_valid, 0);
        end
        send_beats(16'h0F0F, 16'h0000, 1'b1, 16, 15);
        chk("after_err_img_bus", img_bus, exp_img);
        res_ready = 1'b1;
        wait_res();
        chk("after_err_res_class", res_class, 1);
        step();
        res_ready = 1'b0;
        chk("after_err_frame_cnt", frame_cnt, 1);

        // Backpressure: verdict held for 10 cycles, beats ignored.
        send_beats(16'h3C3C, 16'h0001, 1'b1, 16, 15);
        wait_res();
        fc0 = frame_cnt;
        for (int i = 0; i < 10; i++) begin
            in_valid   = 1'b1;
            in_data    = 16'($urandom);
            in_last    = 1'(i);
            cls_result = 1'(i);
            step();
            chk("hold_res_valid", res_valid, 1);
            chk("hold_res_class", res_class, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_img_bus", img_bus, exp_img);
            chk("hold_frame_cnt", frame_cnt, fc0);
        end
        in_valid = 1'b0; in_last = 1'b0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("hold_release_frame_cnt", frame_cnt, fc0 + 16'd1);
        chk("hold_release_res_valid", res_valid, 0);

        // cls_result toggling through SETTLE: only the last settle cycle counts.
        for (int ph = 0; ph < 2; ph++) begin
            send_beats(16'h5A5A, 16'h0000, 1'(ph), 16, 15);
            for (int k = 0; k < 4; k++) begin
                cls_result = 1'(ph) ^ 1'(k);
                step();
            end
            cls_result = 1'(ph);
            step();
            chk("toggle_res_class", res_class, ph == 0 ? 1 : 0);
            res_ready = 1'b1;
            step();
            res_ready = 1'b0;
        end

        // Reset mid-frame (during beat 9), then reset while a verdict is pending.
        send_beats(16'h7777, 16'h0000, 1'b1, 9, 99);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midframe_rst_in_ready", in_ready, 1);
        chk("midframe_rst_img_bus", img_bus, 0);
        chk("midframe_rst_frame_cnt", frame_cnt, 0);
        chk("midframe_rst_diseased_cnt", diseased_cnt, 0);
        chk("midframe_rst_img_stable", img_stable, 0);
        send_beats(16'hC3C3, 16'h0000, 1'b1, 16, 15);
        chk("post_rst_img_stable", img_stable, 1);
        wait_res();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("post_rst_frame_cnt", frame_cnt, 1);
        send_beats(16'h8888, 16'h0000, 1'b1, 16, 15);
        wait_res();
        rst = 1'b1; res_ready = 1'b1;
        step();
        rst = 1'b0; res_ready = 1'b0;
        chk("result_rst_res_valid", res_valid, 0);
        chk("result_rst_res_class", res_class, 0);
        chk("result_rst_frame_cnt", frame_cnt, 0);
        chk("result_rst_diseased_cnt", diseased_cnt, 0);
        chk("result_rst_in_ready", in_ready, 1);
        chk("result_rst_img_bus", img_bus, 0);
        step(); step();
        chk("result_rst_no_emit", res_valid, 0);

        // Saturation: five diseased frames on the 2-bit counter instance.
        do_reset();
        res_ready = 1'b1;
        for (int f = 0; f < 5; f++) begin
            send_beats(16'hFFFF, 16'h0000, 1'b1, 16, 15);
            wait_res();
            step();
        end
        res_ready = 1'b0;
        chk("sat_frame_cnt", frame_cnt_s, 3);
        chk("sat_diseased_cnt", diseased_cnt_s, 3);
        chk("wide_frame_cnt", frame_cnt, 5);
        chk("wide_diseased_cnt", diseased_cnt, 5);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
